comp_debouncer: RTL and testbench

COMP_DEBOUNCER -- requirements
Module: comp_debouncer

---
 rtl/comp_debouncer.sv | 100 ++++++++++
 tb/tb_comp_debouncer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/comp_debouncer.sv
// ---------------------------------------------------------------------------
// comp_debouncer
//   Five-channel debouncer for asynchronous comparator/switch levels. Each
//   channel passes through a two-flop synchronizer. A per-channel counter then
//   requires a changed level to persist for DB_CNT consecutive edges before it
//   is accepted into comps. hold freezes acceptance; while it is high, counters
//   saturate at DB_CNT-1 so that the update happens on the first edge after
//   hold is released.
//
//   With hold low, a raw change first sampled at edge k appears on comps after
//   edge k+1+DB_CNT.
//
// Parameters
//   DB_CNT    : consecutive edges a difference must persist (1..255)
//
// Ports
//   clk       : in  1  system clock, rising edge
//   rst       : in  1  synchronous, active-high reset
//   comps_raw : in  5  asynchronous channel levels
//   hold      : in  1  freeze request; while it is high, comps does not change
//   comps     : out 5  debounced, registered channel levels
//   changed   : out 1  one-cycle pulse in the cycle comps takes a new value
//   stable    : out 1  high when no channel has a pending difference
// ---------------------------------------------------------------------------
module comp_debouncer #(
    parameter int DB_CNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] comps_raw,
    input  logic       hold,
    output logic [4:0] comps,
    output logic       changed,
    output logic       stable
);

    localparam int         NCH     = 5;
    localparam logic [7:0] CNT_MAX = 8'(DB_CNT - 1);

    logic [NCH-1:0]      sync1_q, sync1_d;
    logic [NCH-1:0]      sync2_q, sync2_d;
    logic [NCH-1:0]      comps_q, comps_d;
    logic [NCH-1:0][7:0] cnt_q, cnt_d;
    logic                changed_q, changed_d;
    logic                stable_q, stable_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave a value unassigned and infer a latch.
        sync1_d = comps_raw;
        sync2_d = sync1_q;
        comps_d = comps_q;
        cnt_d   = cnt_q;

        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] == comps_q[i]) begin
                // No difference, or a glitch that returned: restart the count.
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] < CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else if (!hold) begin
                comps_d[i] = sync2_q[i];
                cnt_d[i]   = 8'd0;
            end
            // Otherwise hold is high: the counter stays saturated at CNT_MAX.
        end

        changed_d = |(comps_d ^ comps_q);
        // stable is computed from the next-state values so that it drops in
        // the same cycle a difference first appears on sync2.
        stable_d  = ~|(sync2_d ^ comps_d);
    end

    // NOTE: state flops use non-blocking assignments so that every flop
    // samples the pre-edge values, regardless of statement order.
    // The counters are included in the reset because a reset must discard
    // any count in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            comps_q   <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
            stable_q  <= 1'b1;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            comps_q   <= comps_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
            stable_q  <= stable_d;
        end
    end

    assign comps   = comps_q;
    assign changed = changed_q;
    assign stable  = stable_q;

endmodule

// File: tb/tb_comp_debouncer.sv
// ---------------------------------------------------------------------------
// tb_comp_debouncer
//   Directed bench for comp_debouncer with DB_CNT=4. A cycle-by-cycle table
//   drives rst/hold/comps_raw and gives the expected comps/changed/stable
//   after each rising edge. Hand-written sequences cover hold and a reset
//   that interrupts a count.
// ---------------------------------------------------------------------------
module tb_comp_debouncer;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold = 1'b0;
    logic [4:0] comps_raw = '0;
    logic [4:0] comps;
    logic       changed;
    logic       stable;

    int tests = 0;
    int fails = 0;

    comp_debouncer #(.DB_CNT(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .comps_raw (comps_raw),
        .hold      (hold),
        .comps     (comps),
        .changed   (changed),
        .stable    (stable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       hold;
        logic [4:0] raw;
        logic [4:0] e_comps;
        logic       e_changed;
        logic       e_stable;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic h, input logic [4:0] raw,
                       input logic [4:0] ec, input logic ech, input logic est);
        vec_t v;
        v.rst = r; v.hold = h; v.raw = raw;
        v.e_comps = ec; v.e_changed = ech; v.e_stable = est;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [4:0] ec,
                             input logic ech, input logic est);
        check({tag, ".comps"},   comps,          ec);
        check({tag, ".changed"}, {4'b0, changed}, {4'b0, ech});
        check({tag, ".stable"},  {4'b0, stable},  {4'b0, est});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles, raw all zero.
        add(1, 0, 5'b00000, 5'b00000, 0, 1);
        add(1, 0, 5'b00000, 5'b00000, 0, 1);
        add(0, 0, 5'b00000, 5'b00000, 0, 1);
        add(0, 0, 5'b00000, 5'b00000, 0, 1);
        // Glitch: bit0 high for three edges, then low. It must not be accepted.
        add(0, 0, 5'b00001, 5'b00000, 0, 1);   // k: sync1 takes it
        add(0, 0, 5'b00001, 5'b00000, 0, 0);   // k+1: sync2 differs
        add(0, 0, 5'b00001, 5'b00000, 0, 0);   // cnt=1
        add(0, 0, 5'b00000, 5'b00000, 0, 0);   // cnt=2
        add(0, 0, 5'b00000, 5'b00000, 0, 1);   // cnt=3, sync2 back to 0
        add(0, 0, 5'b00000, 5'b00000, 0, 1);   // counter cleared
        add(0, 0, 5'b00000, 5'b00000, 0, 1);
        // 00000 -> 00101, accepted after edge k+5.
        add(0, 0, 5'b00101, 5'b00000, 0, 1);   // k
        add(0, 0, 5'b00101, 5'b00000, 0, 0);   // k+1
        add(0, 0, 5'b00101, 5'b00000, 0, 0);
        add(0, 0, 5'b00101, 5'b00000, 0, 0);
        add(0, 0, 5'b00101, 5'b00000, 0, 0);
        add(0, 0, 5'b00101, 5'b00101, 1, 1);   // k+5
        add(0, 0, 5'b00101, 5'b00101, 0, 1);
        // Back to 00000.
        add(0, 0, 5'b00000, 5'b00101, 0, 1);
        add(0, 0, 5'b00000, 5'b00101, 0, 0);
        add(0, 0, 5'b00000, 5'b00101, 0, 0);
        add(0, 0, 5'b00000, 5'b00101, 0, 0);
        add(0, 0, 5'b00000, 5'b00101, 0, 0);
        add(0, 0, 5'b00000, 5'b00000, 1, 1);
        add(0, 0, 5'b00000, 5'b00000, 0, 1);
        // bit1 rises at k, bit4 at k+2: two separate pulses.
        add(0, 0, 5'b00010, 5'b00000, 0, 1);   // k
        add(0, 0, 5'b00010, 5'b00000, 0, 0);   // k+1
        add(0, 0, 5'b10010, 5'b00000, 0, 0);   // k+2
        add(0, 0, 5'b10010, 5'b00000, 0, 0);
        add(0, 0, 5'b10010, 5'b00000, 0, 0);
        add(0, 0, 5'b10010, 5'b00010, 1, 0);   // k+5
        add(0, 0, 5'b10010, 5'b00010, 0, 0);
        add(0, 0, 5'b10010, 5'b10010, 1, 1);   // k+7
        add(0, 0, 5'b10010, 5'b10010, 0, 1);
        // Adjacent-edge updates: bit0 rises at k, bit2 at k+1 -> two pulses.
        add(0, 0, 5'b10011, 5'b10010, 0, 1);   // k
        add(0, 0, 5'b10111, 5'b10010, 0, 0);
        add(0, 0, 5'b10111, 5'b10010, 0, 0);
        add(0, 0, 5'b10111, 5'b10010, 0, 0);
        add(0, 0, 5'b10111, 5'b10010, 0, 0);
        add(0, 0, 5'b10111, 5'b10011, 1, 0);   // k+5
        add(0, 0, 5'b10111, 5'b10111, 1, 1);   // k+6
        add(0, 0, 5'b10111, 5'b10111, 0, 1);

        #1;
        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            hold      = vecs[i].hold;
            comps_raw = vecs[i].raw;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].e_comps,
                      vecs[i].e_changed, vecs[i].e_stable);
        end

        // Hold: raw=11111 for 10 cycles, with comps frozen.
        rst = 1'b1; comps_raw = '0; hold = 1'b0;
        step();
        check_out("hold_rst", 5'b00000, 0, 1);
        rst = 1'b0; hold = 1'b1; comps_raw = 5'b11111;
        for (int c = 0; c < 10; c++) begin
            step();
            check({"hold.comps"}, comps, 5'b00000);
            check({"hold.changed"}, {4'b0, changed}, 5'b0);
        end
        check("hold.stable", {4'b0, stable}, 5'b0);
        hold = 1'b0;
        step();
        check_out("hold_release", 5'b11111, 1, 1);
        step();
        check_out("hold_after", 5'b11111, 0, 1);

        // Reset while a channel counter is at 2, followed by full latency after release.
        rst = 1'b1; comps_raw = '0;
        step();
        rst = 1'b0;
        step();
        comps_raw = 5'b00001;
        step();                                  // k
        step();                                  // k+1
        step();                                  // k+2: cnt=1
        step();                                  // k+3: cnt=2
        check_out("pre_rst", 5'b00000, 0, 0);
        rst = 1'b1;
        step();
        check_out("mid_rst", 5'b00000, 0, 1);
        rst = 1'b0;
        for (int c = 0; c < DB + 1; c++) begin   // edges m .. m+4
            step();
            check(c == 0 ? "rr.comps_m" : "rr.comps_wait", comps, 5'b00000);
            check("rr.changed_wait", {4'b0, changed}, 5'b0);
        end
        step();                                  // m+5
        check_out("rr_accept", 5'b00001, 1, 1);
        step();
        check_out("rr_after", 5'b00001, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
